// File: rtl/digit_scan_scheduler_pkg.sv
// Shared definitions for the 4-digit 7-segment scan scheduler:
// FSM state encoding, active-low anode patterns and nibble/anode selectors.
package digit_scan_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRE_BLANK  = 2'd1,
        ST_ACTIVE     = 2'd2,
        ST_POST_BLANK = 2'd3
    } scan_state_e;

    // Anodes are active-low, packed {an3, an2, an1, an0}.
    localparam logic [3:0] ANODES_OFF = 4'b1111;
    localparam logic [3:0] AN3        = 4'b0111;
    localparam logic [3:0] AN2        = 4'b1011;
    localparam logic [3:0] AN1        = 4'b1101;
    localparam logic [3:0] AN0        = 4'b1110;

    // Scan order runs from the leftmost digit down to digit 0.
    localparam logic [1:0] DIGIT_FIRST = 2'd3;
    localparam logic [1:0] DIGIT_LAST  = 2'd0;

    // Full brightness keeps the anode on for the whole active window.
    localparam logic [3:0] BRIGHT_FULL = 4'd15;

    // Character nibble for a digit: [15:12]=digit 3 ... [3:0]=digit 0.
    function automatic logic [3:0] nibble_sel(input logic [15:0] msg,
                                              input logic [1:0]  idx);
        logic [3:0] nib;
        case (idx)
            2'd3:    nib = msg[15:12];
            2'd2:    nib = msg[11:8];
            2'd1:    nib = msg[7:4];
            2'd0:    nib = msg[3:0];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

    // Active-low anode pattern that lights exactly one digit.
    function automatic logic [3:0] anode_sel(input logic [1:0] idx);
        logic [3:0] an;
        case (idx)
            2'd3:    an = AN3;
            2'd2:    an = AN2;
            2'd1:    an = AN1;
            2'd0:    an = AN0;
            default: an = ANODES_OFF;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/digit_scan_scheduler_scan_pwm_gen.sv
// Brightness PWM for the active window of a digit slot. The counter clears
// when the slot enters ACTIVE and free-runs (mod 16) while it stays there.
// pwm_on is the on/off decision for the coming cycle, so the parent can
// register it straight into the anode outputs.
module scan_pwm_gen
    import digit_scan_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       active_nxt,    // next cycle is an ACTIVE cycle
    input  logic       active_entry,  // next cycle is the first ACTIVE cycle
    input  logic [3:0] brightness,    // latched frame brightness
    output logic       pwm_on
);

    logic [3:0] pwm_cnt_r;
    logic [3:0] pwm_cnt_nxt_s;

    // Next PWM count and the compare against brightness for that count.
    always_comb begin
        pwm_cnt_nxt_s = 4'd0;
        pwm_on        = 1'b0;
        if (active_entry) begin
            pwm_cnt_nxt_s = 4'd0;
        end else if (active_nxt) begin
            pwm_cnt_nxt_s = pwm_cnt_r + 4'd1;
        end else begin
            pwm_cnt_nxt_s = 4'd0;
        end

        if (!active_nxt) begin
            pwm_on = 1'b0;
        end else if (brightness == BRIGHT_FULL) begin
            pwm_on = 1'b1;
        end else begin
            pwm_on = (pwm_cnt_nxt_s < brightness);
        end
    end

    // PWM counter register; holds the count of the current cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt_r <= 4'd0;
        end else begin
            pwm_cnt_r <= pwm_cnt_nxt_s;
        end
    end

endmodule

// File: rtl/digit_scan_scheduler.sv
// Scan scheduler for the 4-digit multiplexed 7-segment display.
// Each digit slot is pre-blank / active / post-blank; the frame message and
// brightness are latched only at frame boundaries so a frame never tears.
// An override source wins arbitration at the boundary and is acknowledged.
module digit_scan_scheduler
    import digit_scan_scheduler_pkg::*;
#(
    parameter int DWELL_CYCLES = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] msg_a,
    input  logic        ovr_req,
    input  logic [15:0] ovr_msg,
    output logic        ovr_ack,
    input  logic [3:0]  brightness,
    output logic [3:0]  anodes,
    output logic [3:0]  current_char,
    output logic [1:0]  digit_idx,
    output logic        frame_start
);

    localparam int SLOT_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [SLOT_W-1:0] SLOT_ZERO  = {SLOT_W{1'b0}};
    localparam logic [SLOT_W-1:0] SLOT_ONE   = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(DWELL_CYCLES - 1);
    localparam logic [SLOT_W-1:0] ACT_START  = SLOT_W'(BLANK_CYCLES);
    localparam logic [SLOT_W-1:0] POST_START = SLOT_W'(DWELL_CYCLES - BLANK_CYCLES);

    scan_state_e       state_r,   state_nxt_s;
    logic [SLOT_W-1:0] slot_r,    slot_nxt_s;
    logic [1:0]        digit_r,   digit_nxt_s;
    logic [15:0]       msg_r,     msg_nxt_s;
    logic [3:0]        bright_r,  bright_nxt_s;
    logic [3:0]        char_r,    char_nxt_s;
    logic [3:0]        anodes_r,  anodes_nxt_s;
    logic              ack_r,     ack_nxt_s;
    logic              fs_r,      fs_nxt_s;
    logic              boundary_s;
    logic              active_nxt_s;
    logic              active_entry_s;
    logic              pwm_on_s;

    // Frame boundary: any IDLE cycle, or the final post-blank cycle of digit 0.
    always_comb begin
        boundary_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                boundary_s = 1'b1;
            end
            ST_POST_BLANK: begin
                if ((slot_r == SLOT_LAST) && (digit_r == DIGIT_LAST)) begin
                    boundary_s = 1'b1;
                end else begin
                    boundary_s = 1'b0;
                end
            end
            default: begin
                boundary_s = 1'b0;
            end
        endcase
    end

    // Next-state logic: slot counter, digit order, boundary arbitration/latch.
    always_comb begin
        state_nxt_s  = state_r;
        slot_nxt_s   = slot_r;
        digit_nxt_s  = digit_r;
        msg_nxt_s    = msg_r;
        bright_nxt_s = bright_r;
        char_nxt_s   = char_r;
        ack_nxt_s    = 1'b0;
        fs_nxt_s     = 1'b0;

        if (boundary_s) begin
            if (en) begin
                // Override has priority; the choice holds for the whole frame.
                if (ovr_req) begin
                    msg_nxt_s = ovr_msg;
                end else begin
                    msg_nxt_s = msg_a;
                end
                state_nxt_s  = ST_PRE_BLANK;
                slot_nxt_s   = SLOT_ZERO;
                digit_nxt_s  = DIGIT_FIRST;
                bright_nxt_s = brightness;
                char_nxt_s   = nibble_sel(msg_nxt_s, DIGIT_FIRST);
                ack_nxt_s    = ovr_req;
                fs_nxt_s     = 1'b1;
            end else begin
                state_nxt_s = ST_IDLE;
                slot_nxt_s  = SLOT_ZERO;
            end
        end else if (slot_r == SLOT_LAST) begin
            // Hand the next slot to the next digit; its char leads its anode.
            state_nxt_s = ST_PRE_BLANK;
            slot_nxt_s  = SLOT_ZERO;
            digit_nxt_s = digit_r - 2'd1;
            char_nxt_s  = nibble_sel(msg_r, digit_r - 2'd1);
        end else begin
            slot_nxt_s = slot_r + SLOT_ONE;
            if (slot_nxt_s < ACT_START) begin
                state_nxt_s = ST_PRE_BLANK;
            end else if (slot_nxt_s < POST_START) begin
                state_nxt_s = ST_ACTIVE;
            end else begin
                state_nxt_s = ST_POST_BLANK;
            end
        end
    end

    // Anode pattern for the coming cycle: one digit lit only while PWM is on.
    always_comb begin
        active_nxt_s   = (state_nxt_s == ST_ACTIVE);
        active_entry_s = active_nxt_s && (state_r != ST_ACTIVE);
        anodes_nxt_s   = ANODES_OFF;
        if (pwm_on_s) begin
            anodes_nxt_s = anode_sel(digit_nxt_s);
        end else begin
            anodes_nxt_s = ANODES_OFF;
        end
    end

    // Brightness is only consulted inside ACTIVE, never on a boundary cycle,
    // so the already-latched value is the one that applies.
    scan_pwm_gen u_pwm (
        .clk          (clk),
        .reset        (reset),
        .active_nxt   (active_nxt_s),
        .active_entry (active_entry_s),
        .brightness   (bright_r),
        .pwm_on       (pwm_on_s)
    );

    // State, frame latch and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            slot_r   <= SLOT_ZERO;
            digit_r  <= DIGIT_FIRST;
            msg_r    <= 16'h0000;
            bright_r <= 4'd0;
            char_r   <= 4'h0;
            anodes_r <= ANODES_OFF;
            ack_r    <= 1'b0;
            fs_r     <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            slot_r   <= slot_nxt_s;
            digit_r  <= digit_nxt_s;
            msg_r    <= msg_nxt_s;
            bright_r <= bright_nxt_s;
            char_r   <= char_nxt_s;
            anodes_r <= anodes_nxt_s;
            ack_r    <= ack_nxt_s;
            fs_r     <= fs_nxt_s;
        end
    end

    assign anodes       = anodes_r;
    assign current_char = char_r;
    assign digit_idx    = digit_r;
    assign ovr_ack      = ack_r;
    assign frame_start  = fs_r;

endmodule

// File: tb/tb_digit_scan_scheduler.sv
// Bench for digit_scan_scheduler: two instances (DWELL 8 and 40, BLANK 2)
// share stimulus; a frame-position model predicts every output each cycle,
// and directed hand-computed expectations pin the model.
module tb_digit_scan_scheduler;

    localparam int BL = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] msg_a;
    logic        ovr_req;
    logic [15:0] ovr_msg;
    logic [3:0]  brightness;

    logic [3:0]  an8, ch8, an40, ch40;
    logic [1:0]  dg8, dg40;
    logic        ack8, fs8, ack40, fs40;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    digit_scan_scheduler #(.DWELL_CYCLES(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .en(en), .msg_a(msg_a), .ovr_req(ovr_req),
        .ovr_msg(ovr_msg), .ovr_ack(ack8), .brightness(brightness),
        .anodes(an8), .current_char(ch8), .digit_idx(dg8), .frame_start(fs8)
    );

    digit_scan_scheduler #(.DWELL_CYCLES(40), .BLANK_CYCLES(2)) dut40 (
        .clk(clk), .reset(reset), .en(en), .msg_a(msg_a), .ovr_req(ovr_req),
        .ovr_msg(ovr_msg), .ovr_ack(ack40), .brightness(brightness),
        .anodes(an40), .current_char(ch40), .digit_idx(dg40), .frame_start(fs40)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dw(input int k);
        return (k == 0) ? 8 : 40;
    endfunction

    // Model: frame-level view. m_t is the cycle index inside the running frame.
    bit          m_run [2];
    int          m_t   [2];
    logic [15:0] m_msg [2];
    int          m_br  [2];
    bit          m_ack [2];
    logic [3:0]  m_last[2];

    // Advance the model one clock: boundary when idle or at the frame's last cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_run[k] <= 1'b0;
                m_t[k]   <= 0;
                m_ack[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!m_run[k] || m_t[k] == 4 * dw(k) - 1) begin
                    m_t[k] <= 0;
                    if (en) begin
                        m_run[k] <= 1'b1;
                        m_msg[k] <= ovr_req ? ovr_msg : msg_a;
                        m_br[k]  <= int'(brightness);
                        m_ack[k] <= ovr_req;
                    end else begin
                        m_run[k] <= 1'b0;
                    end
                end else begin
                    m_t[k] <= m_t[k] + 1;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        int s, d, dd, p;
        bit on;
        logic [3:0] ea, ec, ga, gc;
        logic [1:0] gd;
        logic gfs, gack;
        if (reset) begin
            m_last[0] = 4'h0;
            m_last[1] = 4'h0;
        end else if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                ga   = (k == 0) ? an8  : an40;
                gc   = (k == 0) ? ch8  : ch40;
                gd   = (k == 0) ? dg8  : dg40;
                gfs  = (k == 0) ? fs8  : fs40;
                gack = (k == 0) ? ack8 : ack40;
                dd = dw(k);
                if (m_run[k]) begin
                    s  = m_t[k] % dd;
                    d  = 3 - m_t[k] / dd;
                    p  = (s - BL) % 16;
                    on = (s >= BL) && (s < dd - BL) && (m_br[k] == 15 || p < m_br[k]);
                    ea = on ? (4'hF ^ (4'h1 << d)) : 4'hF;
                    ec = 4'((m_msg[k] >> (4 * d)) & 16'h000F);
                    m_last[k] = ec;
                    check($sformatf("model_digit_d%0d", dd), 16'(gd), 16'(d));
                    check($sformatf("model_fs_d%0d", dd), 16'(gfs), 16'(m_t[k] == 0));
                    check($sformatf("model_ack_d%0d", dd), 16'(gack), 16'(m_t[k] == 0 && m_ack[k]));
                end else begin
                    ea = 4'hF;
                    ec = m_last[k];
                    check($sformatf("model_fs_idle_d%0d", dd), 16'(gfs), 16'h0000);
                    check($sformatf("model_ack_idle_d%0d", dd), 16'(gack), 16'h0000);
                end
                check($sformatf("model_anodes_d%0d", dd), 16'(ga), 16'(ea));
                check($sformatf("model_char_d%0d", dd), 16'(gc), 16'(ec));
            end
        end
    end

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for frame_start of one instance; returns cycles waited.
    task automatic wait_fs(input bit use40, input int limit, output int waited);
        int i;
        for (i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((use40 ? fs40 : fs8) === 1'b1) break;
        end
        waited = i + 1;
        n_checks++;
        if (i == limit) begin
            n_fail++;
            $display("FAIL wait_frame_start: no frame_start within %0d cycles (t=%0t)", limit, $time);
        end
    endtask

    initial begin
        int w, lowcnt, fscnt;
        reset = 1'b0; en = 1'b1; msg_a = 16'h1234; ovr_req = 1'b0;
        ovr_msg = 16'h0000; brightness = 4'd15;
        #2 reset = 1'b1;
        #1;
        check("reset_anodes", 16'(an8), 16'h000F);
        check("reset_digit", 16'(dg8), 16'h0003);
        check("reset_char", 16'(ch8), 16'h0000);
        check("reset_ack", 16'(ack8), 16'h0000);
        check("reset_fs", 16'(fs8), 16'h0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;

        // Full brightness, msg 1234, DWELL 8.
        wait_fs(1'b0, 20, w);
        check("f1_char_d3", 16'(ch8), 16'h0001);
        check("f1_blank", 16'(an8), 16'h000F);
        skip(2);  check("f1_an3", 16'(an8), 16'h0007);
        skip(8);  check("f1_an2", 16'(an8), 16'h000B); check("f1_char2", 16'(ch8), 16'h0002);
        skip(8);  check("f1_an1", 16'(an8), 16'h000D); check("f1_char3", 16'(ch8), 16'h0003);
        skip(8);  check("f1_an0", 16'(an8), 16'h000E); check("f1_char4", 16'(ch8), 16'h0004);
        skip(4);  check("f1_post", 16'(an8), 16'h000F);
        wait_fs(1'b0, 5, w);
        check("frame_period_32", 16'(w), 16'h0002);

        // Brightness 4 on the long-dwell instance.
        brightness = 4'd4;
        wait_fs(1'b1, 200, w);
        check("b4_char", 16'(ch40), 16'h0001);
        skip(2);  check("b4_act0", 16'(an40), 16'h0007);
        skip(3);  check("b4_act3", 16'(an40), 16'h0007);
        skip(1);  check("b4_act4_off", 16'(an40), 16'h000F);
        skip(12); check("b4_act16", 16'(an40), 16'h0007);
        skip(4);  check("b4_act20_off", 16'(an40), 16'h000F);
        skip(12); check("b4_act32", 16'(an40), 16'h0007);
        skip(3);  check("b4_act35", 16'(an40), 16'h0007);
        skip(1);  check("b4_post", 16'(an40), 16'h000F);

        // Brightness 0: dark for a whole frame.
        brightness = 4'd0;
        wait_fs(1'b0, 40, w);
        lowcnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (an8 !== 4'hF) lowcnt++;
            @(negedge clk);
        end
        check("b0_dark_frame", 16'(lowcnt), 16'h0000);
        brightness = 4'd15;

        // Override requested mid-frame.
        wait_fs(1'b0, 40, w);
        skip(5);
        ovr_msg = 16'hABCD; ovr_req = 1'b1;
        skip(1);  check("ovr_no_tear", 16'(ch8), 16'h0001); check("ovr_no_early_ack", 16'(ack8), 16'h0000);
        wait_fs(1'b0, 40, w);
        check("ovr_char_a", 16'(ch8), 16'h000A); check("ovr_ack", 16'(ack8), 16'h0001);
        skip(1);  check("ovr_ack_pulse", 16'(ack8), 16'h0000);
        skip(2);  ovr_req = 1'b0;
        skip(6);  check("ovr_char_b", 16'(ch8), 16'h000B);
        wait_fs(1'b0, 40, w);
        check("ovr_drop_noack", 16'(ack8), 16'h0000); check("ovr_drop_msga", 16'(ch8), 16'h0001);

        // msg_a changes at cycle 10 of a frame.
        skip(10); msg_a = 16'hFFFF;
        skip(1);  check("msg_mid_hold", 16'(ch8), 16'h0002);
        wait_fs(1'b0, 40, w);
        check("msg_new_frame", 16'(ch8), 16'h000F);
        skip(8);  check("msg_new_d2", 16'(ch8), 16'h000F);
        msg_a = 16'h1234;

        // en dropped mid-frame: frame completes, then idle.
        wait_fs(1'b0, 40, w);
        skip(12); en = 1'b0;
        skip(20);
        check("idle_anodes", 16'(an8), 16'h000F);
        check("idle_char_hold", 16'(ch8), 16'h0004);
        fscnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (fs8 === 1'b1) fscnt++;
            @(negedge clk);
        end
        check("idle_no_fs", 16'(fscnt), 16'h0000);
        en = 1'b1;
        skip(1);
        check("restart_fs", 16'(fs8), 16'h0001);
        check("restart_digit", 16'(dg8), 16'h0003);
        check("restart_char", 16'(ch8), 16'h0001);

        // Reset during ACTIVE of digit 2.
        skip(11);
        check("pre_reset_an2", 16'(an8), 16'h000B);
        #2 reset = 1'b1;
        #1;
        check("async_reset_anodes", 16'(an8), 16'h000F);
        check("async_reset_digit", 16'(dg8), 16'h0003);
        check("async_reset_ack", 16'(ack8), 16'h0000);
        check("async_reset_an40", 16'(an40), 16'h000F);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_fs(1'b0, 10, w);
        check("post_reset_digit", 16'(dg8), 16'h0003);
        check("post_reset_char", 16'(ch8), 16'h0001);
        skip(2);
        check("post_reset_an3", 16'(an8), 16'h0007);
        skip(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
